// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: funct3 codes, trap causes, FSM states.
// Latency: n/a (definitions and pure combinational helpers only).
// Backpressure: n/a.
package mem_pkg;

    // RV32 load/store funct3 encodings (stores reuse the low three codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Exception cause codes
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Access attributes held for the duration of a bus cycle
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } acc_t;

    // Unused funct3 codes (011, 11x) fall through to word size
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3_size(f3))
            SZ_HALF: m = off[0];
            SZ_WORD: m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_sel(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3_size(f3))
            SZ_BYTE: s = 4'b0001 << off;
            SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicate the store operand across lanes so the byte enables pick the right copy
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3_size(f3))
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] exc_cause(input logic we, input logic fault);
        logic [3:0] c;
        case ({we, fault})
            2'b00:   c = EXC_LOAD_MISALIGN;
            2'b01:   c = EXC_LOAD_FAULT;
            2'b10:   c = EXC_STORE_MISALIGN;
            default: c = EXC_STORE_FAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a bus word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3 (size/sign code), offset (addr[1:0]), word (raw bus data), data (extended result).
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sext;

    always_comb begin
        b    = 8'h00;
        h    = 16'h0000;
        sext = ~funct3[2];
        data = word;

        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // offset[0] is ignored for halfwords so untrapped misaligned loads read the truncated lane
        h = offset[1] ? word[31:16] : word[15:0];

        case (f3_size(funct3))
            SZ_BYTE: data = {{24{sext & b[7]}}, b};
            SZ_HALF: data = {{16{sext & h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32 MEM-stage load/store unit driving a classic Wishbone master port.
// Latency: 3 cycles req->done when the slave acks in its first bus cycle; 2 for a trapped misalign.
// Backpressure: stall_o holds the pipeline while a request waits in IDLE and throughout BUS.
// Ports: clk_i/rst_i (sync, active-high); req_i/we_i/funct3_i/addr_i/wdata_i request;
//        stall_o/done_o/rdata_o/exc_o/exc_code_o response; wbm_* Wishbone master.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW            = 32,
    parameter int TIMEOUT       = 255,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          stall_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          exc_o,
    output logic [3:0]    exc_code_o,
    output logic [AW-1:0] wbm_addr_o,
    output logic [31:0]   wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    input  logic [31:0]   wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t      state_q;
    acc_t        acc_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        trap;

    load_align u_load_align (
        .funct3 (acc_q.funct3),
        .offset (acc_q.off),
        .word   (wbm_dat_i),
        .data   (load_data)
    );

    // cnt_q counts completed BUS cycles; abort at the end of the TIMEOUT-th one
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign trap        = (MISALIGN_TRAP != 0) && is_misaligned(funct3_i, addr_i[1:0]);

    assign stall_o = ~rst_i & (((state_q == ST_IDLE) & req_i) | (state_q == ST_BUS));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            exc_o      <= 1'b0;
            exc_code_o <= '0;
            wbm_addr_o <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
        end else begin
            // Response fields are only meaningful for the single DONE cycle
            done_o     <= 1'b0;
            rdata_o    <= '0;
            exc_o      <= 1'b0;
            exc_code_o <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        acc_q <= '{we: we_i, funct3: funct3_i, off: addr_i[1:0]};
                        cnt_q <= '0;
                        if (trap) begin
                            state_q    <= ST_DONE;
                            done_o     <= 1'b1;
                            exc_o      <= 1'b1;
                            exc_code_o <= exc_cause(we_i, 1'b0);
                        end else begin
                            state_q    <= ST_BUS;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            wbm_we_o   <= we_i;
                            wbm_addr_o <= {addr_i[AW-1:2], 2'b00};
                            wbm_sel_o  <= we_i ? store_sel(funct3_i, addr_i[1:0]) : 4'b1111;
                            wbm_dat_o  <= we_i ? store_data(funct3_i, wdata_i) : 32'h0;
                        end
                    end
                end

                ST_BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // err beats ack; a real ack beats a coincident timeout
                    if (wbm_err_i || wbm_ack_i || timeout_hit) begin
                        state_q    <= ST_DONE;
                        done_o     <= 1'b1;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        wbm_addr_o <= '0;
                        wbm_sel_o  <= '0;
                        wbm_dat_o  <= '0;
                        if (wbm_err_i || !wbm_ack_i) begin
                            exc_o      <= 1'b1;
                            exc_code_o <= exc_cause(acc_q.we, 1'b1);
                        end else if (!acc_q.we) begin
                            rdata_o <= load_data;
                        end
                    end
                end

                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with a queue scoreboard and independent monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, exc_o;
    logic [31:0] rdata_o;
    logic [3:0]  exc_code_o;
    logic [31:0] wbm_addr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(32), .TIMEOUT(4), .MISALIGN_TRAP(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
        .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  code;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_rdata"}, rdata_o, e.rdata);
                chk({e.name, "_exc"}, {31'd0, exc_o}, {31'd0, e.exc});
                chk({e.name, "_code"}, {28'd0, exc_code_o}, {28'd0, e.code});
                chk({e.name, "_cycle"}, cyc_n, e.cyc);
            end
        end
    end

    // Issue one access, play the slave, and check the bus-side view.
    // resp_n: BUS cycle in which the slave responds (0 = never).
    task automatic txn(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rsp,
                       input int resp_n, input logic r_ack, input logic r_err,
                       input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                       input logic [31:0] exp_dat, input int exp_bus,
                       input logic [31:0] exp_rdata, input logic exp_exc, input logic [3:0] exp_code);
        exp_t e;
        int   n;
        bit   fin;
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        e.name = name; e.rdata = exp_rdata; e.exc = exp_exc; e.code = exp_code;
        e.cyc = cyc_n + 1 + exp_bus;
        exp_q.push_back(e);
        #1;
        chk({name, "_stall_req"}, {31'd0, stall_o}, 32'd1);
        n = 0;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            req_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            if (done_o) begin
                fin = 1'b1;
                chk({name, "_stall_done"}, {31'd0, stall_o}, 32'd0);
            end else if (wbm_cyc_o) begin
                n++;
                if (n == 1) begin
                    chk({name, "_stall_bus"}, {31'd0, stall_o}, 32'd1);
                    chk({name, "_stb"}, {31'd0, wbm_stb_o}, 32'd1);
                    chk({name, "_we"}, {31'd0, wbm_we_o}, {31'd0, we});
                    chk({name, "_addr"}, wbm_addr_o, exp_addr);
                    chk({name, "_sel"}, {28'd0, wbm_sel_o}, {28'd0, exp_sel});
                    if (we) chk({name, "_dat"}, wbm_dat_o, exp_dat);
                end
                if (n == resp_n) begin
                    wbm_ack_i = r_ack; wbm_err_i = r_err; wbm_dat_i = rsp;
                end
            end
        end
        if (!fin) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        chk({name, "_bus_cycles"}, n, exp_bus);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = '0; wdata_i = '0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        chk("rst_sel_exc", {23'd0, wbm_sel_o, exc_o, exc_code_o}, 32'd0);
        chk("rst_addr", wbm_addr_o, 32'd0);
        chk("rst_wdat", wbm_dat_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_i = 1'b0;

        //  name       we    f3      addr          wdata         rsp          rn ack err  wb addr       sel      dat          bus rdata         exc  code
        txn("lb",      1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 1'b1, 1'b0, 32'h0000_1000, 4'b1111, 32'h0,        1, 32'hFFFF_FF80, 1'b0, 4'd0);
        txn("sh",      1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        1, 1'b1, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,        1'b0, 4'd0);
        txn("lw_mis",  1'b0, 3'b010, 32'h0000_1001, 32'h0,        32'h0,        0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'h0,        1'b1, 4'd4);
        txn("sw_err",  1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, 32'h0,        2, 1'b1, 1'b1, 32'h0000_4000, 4'b1111, 32'h1234_5678, 2, 32'h0,        1'b1, 4'd7);
        txn("lw_tmo",  1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h0,        0, 1'b0, 1'b0, 32'h0000_5000, 4'b1111, 32'h0,        4, 32'h0,        1'b1, 4'd5);
        txn("lhu",     1'b0, 3'b101, 32'h0000_6002, 32'h0,        32'hABCD_1234, 1, 1'b1, 1'b0, 32'h0000_6000, 4'b1111, 32'h0,        1, 32'h0000_ABCD, 1'b0, 4'd0);
        txn("lh",      1'b0, 3'b001, 32'h0000_6000, 32'h0,        32'h1234_8001, 1, 1'b1, 1'b0, 32'h0000_6000, 4'b1111, 32'h0,        1, 32'hFFFF_8001, 1'b0, 4'd0);
        txn("lbu",     1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h1122_3344, 3, 1'b1, 1'b0, 32'h0000_7000, 4'b1111, 32'h0,        3, 32'h0000_0033, 1'b0, 4'd0);
        txn("sb",      1'b1, 3'b000, 32'h0000_7002, 32'hAAAA_AA5C, 32'h0,        1, 1'b1, 1'b0, 32'h0000_7000, 4'b0100, 32'h5C5C_5C5C, 1, 32'h0,        1'b0, 4'd0);
        txn("sh_mis",  1'b1, 3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'h0,        0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'h0,        1'b1, 4'd6);
        txn("lb_err",  1'b0, 3'b000, 32'h0000_9000, 32'h0,        32'h0,        1, 1'b0, 1'b1, 32'h0000_9000, 4'b1111, 32'h0,        1, 32'h0,        1'b1, 4'd5);

        // ack/err while idle must be ignored
        @(posedge clk); #1;
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        chk("idle_ack_done", {31'd0, done_o}, 32'd0);
        chk("idle_ack_cyc", {31'd0, wbm_cyc_o}, 32'd0);

        // reset in the middle of a bus cycle, then a stale ack
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_3000;
        @(posedge clk); #1;
        req_i = 1'b0;
        chk("rstbus_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rstbus_cyc_after", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rstbus_stb_after", {31'd0, wbm_stb_o}, 32'd0);
        rst_i = 1'b0;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstbus_late_ack_done", {31'd0, done_o}, 32'd0);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AW, default 32: Wishbone address width, 32 or less.
REQ-002 SHALL have parameter TIMEOUT, default 255: bus-wait cycles before fault; 0 disables the timeout.
REQ-003 SHALL have parameter MISALIGN_TRAP, default 1: 1 traps misaligned accesses; 0 issues them word-truncated.
REQ-004 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port req_i  in  1  load/store valid in MEM stage.
REQ-007 SHALL have port we_i  in  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3_i  in  3  RV32 size/sign code (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-009 SHALL have port addr_i  in  32  effective byte address (ALU result).
REQ-010 SHALL have port wdata_i  in  32  rs2 store data, unaligned.
REQ-011 SHALL have port stall_o  out  1  holds the pipeline.
REQ-012 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata_o  out  32  extended load data, valid with done_o.
REQ-014 SHALL have port exc_o  out  1  exception, valid with done_o.
REQ-015 SHALL have port exc_code_o  out  4  cause: 4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
REQ-016 SHALL have ports wbm_addr_o (out, AW), wbm_dat_o (out, 32), wbm_sel_o (out, 4), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_we_o (out, 1): classic Wishbone master.
REQ-017 SHALL have ports wbm_dat_i (in, 32), wbm_ack_i (in, 1), wbm_err_i (in, 1): Wishbone slave response.

Function
REQ-018 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE.
- IDLE, req_i=1, access aligned: go to BUS and latch addr, we, funct3 and steered data.
- IDLE, req_i=1, misaligned with MISALIGN_TRAP=1: go directly to DONE with exc_o=1; no bus cycle.
REQ-019 SHALL drive stall_o=1 combinationally when req_i=1 in IDLE, and in BUS; stall_o SHALL be 0 in DONE.
REQ-020 SHALL hold cyc, stb and all Wishbone outputs registered and stable for the whole of BUS.
- wbm_addr_o = {addr[AW-1:2], 2'b00}.
REQ-021 SHALL steer store data: SB replicates the byte across all lanes; SH replicates the halfword; SW passes through.
REQ-022 SHALL set wbm_sel_o: SB = 1<<addr[1:0]; SH = 4'b0011 or 4'b1100 by addr[1]; SW = 4'b1111. For loads, wbm_sel_o = 4'b1111.
REQ-023 SHALL treat addresses as misaligned when: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-024 SHALL, on wbm_ack_i in BUS, drop cyc/stb next cycle, enter DONE, and register rdata_o.
- Lane selected by addr[1:0].
- Sign- or zero-extended per funct3.
- rdata_o = 0 for stores.
REQ-025 SHALL give wbm_err_i priority over a simultaneous wbm_ack_i; err goes to DONE with a fault code of 5 or 7.
REQ-026 SHALL count BUS cycles; at count==TIMEOUT (TIMEOUT>0), abort as fault exactly as for err.
REQ-027 SHALL ignore ack/err outside BUS.
REQ-028 SHALL last exactly one cycle in DONE; done_o=1 there, and 0 elsewhere.
REQ-029 SHALL provide minimum load latency of 3 cycles from req_i to done_o when the slave acks in its first BUS cycle.
REQ-030 SHALL ignore req_i in DONE; the pipeline advances on that edge.
REQ-031 SHALL issue the access word-truncated, with no exception, when MISALIGN_TRAP=0.

Reset
REQ-032 SHALL, with rst_i=1 at a clock edge, force IDLE and clear the timeout counter.
- All outputs 0: stall_o, done_o, exc_o, exc_code_o, rdata_o and every wbm_* output.
REQ-033 SHALL, on reset during BUS, deassert cyc/stb on the following cycle; any later ack is ignored.

Structure
REQ-034 SHALL place funct3 encodings, exception cause codes and FSM state encodings in shared package mem_pkg.
REQ-035 SHALL implement load lane extraction and extension in one combinational sub-module, load_align.

Verification
REQ-036 SHALL verify LB: addr 0x1003, slave data 0x80FF_FF00, ack in first BUS cycle -> rdata 0xFFFF_FF80 with done_o on cycle 3.
REQ-037 SHALL verify SH: addr 0x2002, wdata 0x0000_BEEF -> wbm_sel 4'b1100, wbm_dat 0xBEEF_BEEF, wbm_addr 0x2000.
REQ-038 SHALL verify LW at 0x1001 with MISALIGN_TRAP=1 -> no cyc; done_o with exc_code 4 one cycle later.
REQ-039 SHALL verify a store with ack and err in the same cycle -> exc_code 7.
REQ-040 SHALL verify TIMEOUT=4 with a silent slave -> cyc held 4 cycles, then load fault code 5.
REQ-041 SHALL verify reset asserted during BUS -> cyc 0 next cycle; a late ack produces no done_o.
